assoc_cache: RTL
================

# assoc_cache

Parametrised N-way set-associative, write-back, write-allocate data cache for the single-cycle-clocked datapath. It sits between the processor load/store port and the block-wide `dataMemory`. It generalises the direct-mapped, read-only cache by adding configurable geometry, LRU replacement, dirty-block write-back, a request/acknowledge memory handshake and hit/miss counters.

## Interface
- `ADDR_W`, 15: word-address width.
- `WORD_W`, 32: data word width.
- `WORDS`, 4: words per block, power of 2 (`OFF_W = log2(WORDS)`).
- `SETS`, 256: number of sets, power of 2 (`IDX_W = log2(SETS)`, `TAG_W = ADDR_W-IDX_W-OFF_W`).
- `WAYS`, 2: associativity, 1 or 2.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request, sampled only in IDLE.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in ADDR_W: word address, fields {tag, index, offset}.
- `cpu_wdata` in WORD_W: store data.
- `cpu_rdata` out WORD_W: load data, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle pulse when the access completes.
- `hit` / `miss` out 1: one-cycle pulses giving the outcome of the first lookup.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 = block write-back, 0 = block refill.
- `mem_addr` out ADDR_W-OFF_W: block address {tag, index}.
- `mem_wdata` out WORD_W*WORDS: write-back block; word k sits at bits [k*WORD_W +: WORD_W].
- `mem_rdata` in WORD_W*WORDS: refill block, same packing.
- `mem_ack` in 1: transaction done; `mem_rdata` is valid in this cycle.
- `hit_count`, `miss_count` out CNT_W: saturating statistics counters.

## Operation
- Storage per way per set: valid, dirty, tag, block. Each set also holds one LRU bit, which names the least-recently-used way. With `WAYS`=1 the LRU bit is unused.
- FSM states:
  - IDLE: when `cpu_req`=1, latch addr, we and wdata, clear the retry flag, go to LOOKUP.
  - LOOKUP: compare the latched tag against every valid way of the indexed set.
    - Hit:
      - Drive `cpu_rdata` = selected word.
      - On a store, write `cpu_wdata` into that word and set dirty. The load/store path is the same.
      - Set LRU to the other way.
      - Pulse `cpu_ready`.
      - If the retry flag is 0, also pulse `hit` and increment `hit_count`.
      - Go to IDLE.
    - Miss:
      - Pulse `miss` and increment `miss_count`. A miss never occurs with the retry flag set.
      - Victim = lowest-index invalid way, otherwise the LRU way.
      - If the victim is valid and dirty, go to WB; otherwise go to REFILL.
  - WB:
    - Drive `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim block.
    - Stay until `mem_ack`=1, then go to REFILL.
  - REFILL:
    - Drive `mem_req`=1, `mem_we`=0, `mem_addr`={latched tag, index}.
    - On `mem_ack`: write `mem_rdata` into the victim way, set tag, valid=1, dirty=0, set the retry flag, go to LOOKUP.
    - The retried lookup always hits and completes the access, including a store merge.
- `cpu_req` is ignored outside IDLE. The requester holds nothing after acceptance, because inputs are latched.
- Counters saturate at 2^CNT_W-1. They are cleared only by reset.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE.
  - All valid, dirty and LRU bits go to 0.
  - Counters go to 0.
  - `cpu_ready`, `hit`, `miss`, `mem_req`, `mem_we` go to 0. `mem_addr`, `mem_wdata`, `cpu_rdata` go to 0.
  - Tag and data arrays need not reset.
- Reset mid-transaction: `mem_req` drops in the same cycle. The in-flight access is discarded, and a partially written block is never marked valid.
- Hit latency: request sampled at edge n (IDLE to LOOKUP); `cpu_ready`/`hit` are high during cycle n+1; IDLE at n+2. Peak throughput is one access per 2 cycles.
- Miss, clean victim: `miss` is high in the LOOKUP cycle. `mem_req` rises the next cycle and is held through the `mem_ack` cycle inclusive. `cpu_ready` is high in the cycle after `mem_ack`.
- Miss, dirty victim: WB then REFILL run back-to-back. `mem_req` stays high across the transition, and `mem_we` falls the cycle after the first `mem_ack`.
- `mem_addr`, `mem_we` and `mem_wdata` are stable for as long as `mem_req`=1. `mem_ack` while `mem_req`=0 is ignored.
- All outputs are registered or decoded from state plus registered data. There is no combinational path from `mem_ack` to `mem_req`.

## Test plan
Defaults: tag=[14:10], index=[9:2], offset=[1:0].

1. After reset, load 0x0405. Expect: `miss` pulse and REFILL with `mem_addr`=0x101. Ack after 1 cycle with word1=0xDEADBEEF. Expect `cpu_rdata`=0xDEADBEEF with `cpu_ready`, `hit_count`=0, `miss_count`=1.
2. Then load 0x0406. Expect: `hit` and `cpu_ready` in the cycle after acceptance, word2 returned, `mem_req` stays 0.
3. Store 0x12345678 to 0x0405 (hit, dirty), then load 0x0805: refill into way1 with no WB. Then load 0x0C05: expect WB with `mem_addr`=0x101 and word1=0x12345678, followed by REFILL with `mem_addr`=0x301.
4. Hold `mem_ack` low for 5 cycles during a refill. Expect: `mem_req` and `mem_addr` held stable, `cpu_ready`=0, and a `cpu_req` toggled meanwhile is ignored.
5. Assert `rst` during REFILL. Expect: `mem_req`=0 immediately, counters 0, and a subsequent load of 0x0405 misses.
6. With `CNT_W`=4, perform 20 hits. Expect `hit_count` to saturate at 15. With `WAYS`=1, loads of 0x0405 then 0x0805 evict each other on every access.

Source files
------------

// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with LRU replacement,
// request/acknowledge block memory port and saturating hit/miss counters.
module assoc_cache #(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 256,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16,
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [WORD_W-1:0]         cpu_wdata,
  output logic [WORD_W-1:0]         cpu_rdata,
  output logic                      cpu_ready,
  output logic                      hit,
  output logic                      miss,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-OFF_W-1:0]   mem_addr,
  output logic [WORD_W*WORDS-1:0]   mem_wdata,
  input  logic [WORD_W*WORDS-1:0]   mem_rdata,
  input  logic                      mem_ack,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count,
  output logic [1:0]                dbg_state
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = WORD_W * WORDS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_WB     = 2'd2;
  localparam logic [1:0] S_REFILL = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [WORD_W-1:0] wdata_q;
  logic              retry_q;
  logic              victim_q;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  // Two ways are always allocated; with WAYS=1 way 1 is never selected or written.
  logic [SETS-1:0][1:0] valid_q, dirty_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_mem  [SETS][2];
  logic [BLK_W-1:0]     data_mem [SETS][2];

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  assign {tag, idx, off} = addr_q;

  logic             lookup_hit;
  logic             hit_way;
  logic             victim_d;
  logic [BLK_W-1:0] sel_block;

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lookup_hit && valid_q[idx][w] && tag_mem[idx][w] == tag) begin
        lookup_hit = 1'b1;
        hit_way    = w[0];
      end
    end
  end

  // Fill an invalid way first; only a full set consults the LRU bit.
  always_comb begin
    victim_d = 1'b0;
    if (!valid_q[idx][0])                   victim_d = 1'b0;
    else if (WAYS == 2 && !valid_q[idx][1]) victim_d = 1'b1;
    else if (WAYS == 2)                     victim_d = lru_q[idx];
  end

  assign sel_block = data_mem[idx][hit_way];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cpu_req) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (lookup_hit) state_d = S_IDLE;
        else if (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) state_d = S_WB;
        else state_d = S_REFILL;
      end
      S_WB:     if (mem_ack) state_d = S_REFILL;
      S_REFILL: if (mem_ack) state_d = S_LOOKUP;
      default:  state_d = S_IDLE;
    endcase
  end

  assign cpu_ready  = (state_q == S_LOOKUP) && lookup_hit;
  assign hit        = cpu_ready && !retry_q;
  assign miss       = (state_q == S_LOOKUP) && !lookup_hit;
  assign cpu_rdata  = cpu_ready ? sel_block[off*WORD_W +: WORD_W] : '0;
  assign mem_req    = (state_q == S_WB) || (state_q == S_REFILL);
  assign mem_we     = (state_q == S_WB);
  assign mem_addr   = (state_q == S_WB)     ? {tag_mem[idx][victim_q], idx} :
                      (state_q == S_REFILL) ? {tag, idx} : '0;
  assign mem_wdata  = (state_q == S_WB) ? data_mem[idx][victim_q] : '0;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      retry_q    <= 1'b0;
      victim_q   <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (cpu_req) begin
          addr_q  <= cpu_addr;
          we_q    <= cpu_we;
          wdata_q <= cpu_wdata;
          retry_q <= 1'b0;
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            if (we_q) dirty_q[idx][hit_way] <= 1'b1;
            if (WAYS == 2) lru_q[idx] <= ~hit_way;
            if (!retry_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
          end else begin
            victim_q <= victim_d;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
          end
        end
        S_REFILL: if (mem_ack) begin
          valid_q[idx][victim_q] <= 1'b1;
          dirty_q[idx][victim_q] <= 1'b0;
          retry_q                <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clock) begin
    if (state_q == S_LOOKUP && lookup_hit && we_q)
      data_mem[idx][hit_way][off*WORD_W +: WORD_W] <= wdata_q;
    if (state_q == S_REFILL && mem_ack) begin
      data_mem[idx][victim_q] <= mem_rdata;
      tag_mem[idx][victim_q]  <= tag;
    end
  end

endmodule
